// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges in-order pipeline writes with long-latency results
// buffered in a small FIFO, tracks pending destinations and requests a stall on starvation.
module wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_wb_en,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic        issue_en,
  input  logic [4:0]  issue_rd,
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  output logic        wb_en,
  output logic [4:0]  rd_index,
  output logic [31:0] wb_data,
  output logic [31:0] busy,
  output logic        stall_req
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT - 1);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            stall_q, stall_d;
  logic            wb_en_q, wb_en_d;
  logic [4:0]      rd_index_q, rd_index_d;
  logic [31:0]     wb_data_q, wb_data_d;
  logic [31:0]     busy_q, busy_d;
  logic [31:0]     set_mask, clr_mask;

  logic   fifo_empty;
  logic   push;
  logic   pop;
  logic   pipe_live;
  logic   starved;
  entry_t head;

  assign fifo_empty = (count_q == '0);
  assign lu_ready   = (count_q < CW'(DEPTH));
  assign push       = lu_valid && lu_ready;
  assign pipe_live  = pipe_wb_en && (pipe_rd != 5'd0);
  assign pop        = !pipe_live && !fifo_empty;
  assign starved    = pipe_live && !fifo_empty;
  assign head       = mem[rd_ptr_q];

  // NOTE: every signal gets a default at the top of the block so no path can infer a latch.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    wb_en_d    = 1'b0;
    rd_index_d = 5'd0;
    wb_data_d  = 32'd0;
    set_mask   = 32'd0;
    clr_mask   = 32'd0;
    starve_d   = '0;
    stall_d    = 1'b0;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);

    // Pipeline always owns the slot; the FIFO head only drains when it is free.
    if (pipe_live) begin
      wb_en_d    = 1'b1;
      rd_index_d = pipe_rd;
      wb_data_d  = pipe_data;
    end else if (pop && head.rd != 5'd0) begin
      wb_en_d    = 1'b1;
      rd_index_d = head.rd;
      wb_data_d  = head.data;
      clr_mask[head.rd] = 1'b1;
    end

    if (issue_en && issue_rd != 5'd0) set_mask[issue_rd] = 1'b1;
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;

    // Counter restarts with the stall pulse, so an ignored stall re-fires after another full run.
    if (starved) begin
      if (starve_q == STARVE_MAX) stall_d  = 1'b1;
      else                        starve_d = starve_q + SW'(1);
    end
  end

  // NOTE: state flops use non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      stall_q    <= 1'b0;
      wb_en_q    <= 1'b0;
      rd_index_q <= 5'd0;
      wb_data_q  <= 32'd0;
      busy_q     <= 32'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      stall_q    <= stall_d;
      wb_en_q    <= wb_en_d;
      rd_index_q <= rd_index_d;
      wb_data_q  <= wb_data_d;
      busy_q     <= busy_d;
    end
  end

  // NOTE: FIFO storage is not reset; entries are only meaningful below count_q.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= '{rd: lu_rd, data: lu_data};
  end

  assign wb_en     = wb_en_q;
  assign rd_index  = rd_index_q;
  assign wb_data   = wb_data_q;
  assign busy      = busy_q;
  assign stall_req = stall_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: hand-written vector table plus a queue-based
// scoreboard fed by a behavioural model of the FIFO, scoreboard bits and starvation.
module tb_wb_arbiter;
  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pipe_wb_en, issue_en, lu_valid;
  logic [4:0]  pipe_rd, issue_rd, lu_rd;
  logic [31:0] pipe_data, lu_data;
  logic        lu_ready, wb_en, stall_req;
  logic [4:0]  rd_index;
  logic [31:0] wb_data, busy;

  always #5 clk = ~clk;

  wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset(reset),
    .pipe_wb_en(pipe_wb_en), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .issue_en(issue_en), .issue_rd(issue_rd),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data),
    .lu_ready(lu_ready), .wb_en(wb_en), .rd_index(rd_index), .wb_data(wb_data),
    .busy(busy), .stall_req(stall_req)
  );

  typedef struct packed {
    logic        pipe_wb_en;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
  } stim_t;

  typedef struct packed {
    stim_t       s;
    logic        exp_en;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  typedef struct packed {
    logic        wb_en;
    logic        chk_addr;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] busy;
    logic        stall;
  } exp_t;

  int          checks   = 0;
  int          failures = 0;
  ent_t        m_fifo[$];
  exp_t        sb_q[$];
  logic [31:0] m_busy = 32'd0;
  int          m_run  = 0;
  vec_t        tbl[6];
  stim_t       idle_s;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic stim_t mk(input logic pwe, input logic [4:0] prd, input logic [31:0] pd,
                               input logic ie, input logic [4:0] ird,
                               input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    stim_t s;
    s.pipe_wb_en = pwe; s.pipe_rd = prd; s.pipe_data = pd;
    s.issue_en = ie; s.issue_rd = ird;
    s.lu_valid = lv; s.lu_rd = lrd; s.lu_data = ld;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    pipe_wb_en = s.pipe_wb_en; pipe_rd = s.pipe_rd; pipe_data = s.pipe_data;
    issue_en = s.issue_en; issue_rd = s.issue_rd;
    lu_valid = s.lu_valid; lu_rd = s.lu_rd; lu_data = s.lu_data;
  endtask

  task automatic model_reset();
    m_fifo.delete();
    sb_q.delete();
    m_busy = 32'd0;
    m_run  = 0;
  endtask

  // Drive one cycle of stimulus and push the model's prediction for the next edge.
  task automatic drive(input stim_t s);
    exp_t e;
    ent_t h;
    logic live, have, can_push;
    apply(s);
    can_push = (m_fifo.size() < DEPTH);
    check("lu_ready", 32'(lu_ready), 32'(can_push));
    live = s.pipe_wb_en && (s.pipe_rd != 5'd0);
    have = (m_fifo.size() > 0);
    e = '0;
    e.busy = m_busy;
    if (live) begin
      e.wb_en = 1'b1; e.chk_addr = 1'b1; e.rd = s.pipe_rd; e.data = s.pipe_data;
    end else if (have) begin
      h = m_fifo.pop_front();
      if (h.rd != 5'd0) begin
        e.wb_en = 1'b1; e.chk_addr = 1'b1; e.rd = h.rd; e.data = h.data;
        e.busy[h.rd] = 1'b0;
      end
    end else begin
      e.chk_addr = 1'b1;
    end
    if (s.issue_en && s.issue_rd != 5'd0) e.busy[s.issue_rd] = 1'b1;
    if (live && have) begin
      m_run++;
      e.stall = ((m_run % STARVE_LIMIT) == 0);
    end else begin
      m_run = 0;
    end
    if (s.lu_valid && can_push) m_fifo.push_back({s.lu_rd, s.lu_data});
    m_busy = e.busy;
    sb_q.push_back(e);
  endtask

  task automatic cycle(input stim_t s);
    exp_t e;
    drive(s);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_empty: got no prediction expected one (t=%0t)", $time);
    end else begin
      e = sb_q.pop_front();
      check("wb_en", 32'(wb_en), 32'(e.wb_en));
      if (e.chk_addr) begin
        check("rd_index", 32'(rd_index), 32'(e.rd));
        check("wb_data", wb_data, e.data);
      end
      check("busy", busy, e.busy);
      check("stall_req", 32'(stall_req), 32'(e.stall));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int seen;
    int pulses;
    idle_s = mk(0, 0, 0, 0, 0, 0, 0, 0);
    tbl[0] = '{s: mk(1, 5,  32'hDEADBEEF, 0, 0, 0, 0, 0), exp_en: 1, exp_rd: 5,  exp_data: 32'hDEADBEEF};
    tbl[1] = '{s: idle_s,                                  exp_en: 0, exp_rd: 0,  exp_data: 32'h0};
    tbl[2] = '{s: mk(1, 0,  32'h11111111, 1, 0, 0, 0, 0), exp_en: 0, exp_rd: 0,  exp_data: 32'h0};
    tbl[3] = '{s: mk(1, 31, 32'hFFFFFFFF, 0, 0, 0, 0, 0), exp_en: 1, exp_rd: 31, exp_data: 32'hFFFFFFFF};
    tbl[4] = '{s: mk(0, 3,  32'h22222222, 0, 0, 0, 0, 0), exp_en: 0, exp_rd: 0,  exp_data: 32'h0};
    tbl[5] = '{s: mk(1, 1,  32'h00000000, 0, 0, 0, 0, 0), exp_en: 1, exp_rd: 1,  exp_data: 32'h0};

    apply(idle_s);
    #2 reset = 1'b0;
    #1;
    check("rst_wb_en", 32'(wb_en), 32'd0);
    check("rst_rd_index", 32'(rd_index), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_stall", 32'(stall_req), 32'd0);
    check("rst_lu_ready", 32'(lu_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Single-cycle pipeline behaviour against hand-written expectations.
    for (int i = 0; i < 6; i++) begin
      cycle(tbl[i].s);
      check($sformatf("tbl%0d_wb_en", i), 32'(wb_en), 32'(tbl[i].exp_en));
      check($sformatf("tbl%0d_rd", i), 32'(rd_index), 32'(tbl[i].exp_rd));
      check($sformatf("tbl%0d_data", i), wb_data, tbl[i].exp_data);
    end

    // Issue rd7, result returns three cycles later, drains on an idle pipe.
    cycle(mk(0, 0, 0, 1, 7, 0, 0, 0));
    check("issue7_busy", 32'(busy[7]), 32'd1);
    cycle(idle_s);
    cycle(idle_s);
    cycle(mk(0, 0, 0, 0, 0, 1, 7, 32'h12));
    cycle(idle_s);
    check("lu7_wb_en", 32'(wb_en), 32'd1);
    check("lu7_rd", 32'(rd_index), 32'd7);
    check("lu7_data", wb_data, 32'h12);
    check("lu7_busy_clr", 32'(busy[7]), 32'd0);

    // Fill the FIFO under continuous pipe writes, then hold a fifth result.
    for (int i = 0; i < 4; i++)
      cycle(mk(1, 5'(i + 1), 32'hA000 + 32'(i), 0, 0, 1, 5'(10 + i), 32'hB0 + 32'(i)));
    check("full_lu_ready", 32'(lu_ready), 32'd0);
    cycle(mk(1, 5'd5, 32'hA004, 0, 0, 1, 5'd14, 32'hB4));
    cycle(mk(0, 0, 0, 0, 0, 1, 5'd14, 32'hB4));
    cycle(mk(0, 0, 0, 0, 0, 1, 5'd14, 32'hB4));
    for (int i = 0; i < 4; i++) cycle(idle_s);

    // Starvation honoured: stall after STARVE_LIMIT starved cycles, pipe idles, entry drains.
    cycle(mk(1, 5'd20, 32'hC0, 0, 0, 1, 5'd3, 32'h33));
    seen = 0;
    for (int k = 1; k <= 20 && seen == 0; k++) begin
      cycle(mk(1, 5'd20, 32'(k), 0, 0, 0, 0, 0));
      if (stall_req) seen = k;
    end
    check("starve_len", 32'(seen), 32'(STARVE_LIMIT));
    cycle(idle_s);
    check("stall_drain_rd", 32'(rd_index), 32'd3);
    check("stall_drain_data", wb_data, 32'h33);

    // Starvation ignored: pipeline keeps winning, stall re-fires after another full run.
    cycle(mk(1, 5'd21, 32'hD0, 0, 0, 1, 5'd4, 32'h44));
    pulses = 0;
    for (int k = 1; k <= 2 * STARVE_LIMIT + 1; k++) begin
      cycle(mk(1, 5'd21, 32'hD000 + 32'(k), 0, 0, 0, 0, 0));
      if (stall_req) pulses++;
    end
    check("stall_pulses", 32'(pulses), 32'd2);
    cycle(idle_s);

    // Set beats clear on the same register; rd0 FIFO entry is discarded.
    cycle(mk(0, 0, 0, 1, 9, 0, 0, 0));
    cycle(mk(0, 0, 0, 0, 0, 1, 9, 32'h99));
    cycle(mk(0, 0, 0, 1, 9, 0, 0, 0));
    check("setwins_busy9", 32'(busy[9]), 32'd1);
    check("setwins_rd", 32'(rd_index), 32'd9);
    cycle(mk(1, 0, 32'h77, 0, 0, 1, 0, 32'h55));
    cycle(mk(1, 0, 32'h77, 0, 0, 0, 0, 0));
    check("discard_wb_en", 32'(wb_en), 32'd0);
    cycle(mk(0, 0, 0, 0, 0, 1, 9, 32'h9A));
    cycle(idle_s);
    check("busy9_clr", 32'(busy[9]), 32'd0);

    // Mid-operation reset with three entries queued and busy bits 7 and 10 pending.
    cycle(mk(0, 0, 0, 1, 7, 0, 0, 0));
    cycle(mk(0, 0, 0, 1, 10, 0, 0, 0));
    cycle(mk(1, 1, 32'hE1, 0, 0, 1, 7, 32'hF7));
    cycle(mk(1, 2, 32'hE2, 0, 0, 1, 10, 32'hFA));
    cycle(mk(1, 3, 32'hE3, 0, 0, 1, 2, 32'hF2));
    check("pre_rst_busy", busy, 32'h0000_0480);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_wb_en", 32'(wb_en), 32'd0);
    check("mid_rst_rd", 32'(rd_index), 32'd0);
    check("mid_rst_data", wb_data, 32'd0);
    check("mid_rst_busy", busy, 32'd0);
    check("mid_rst_stall", 32'(stall_req), 32'd0);
    check("mid_rst_lu_ready", 32'(lu_ready), 32'd1);
    model_reset();
    apply(idle_s);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) cycle(idle_s);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
